// File: rtl/mirfak_lsu.sv
// rtl/mirfak_lsu.sv - Mirfak WB-stage load/store unit, Wishbone classic data master
module mirfak_lsu (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        lsu_valid_i,
    input  logic        lsu_we_i,
    input  logic [1:0]  lsu_size_i,
    input  logic        lsu_unsigned_i,
    input  logic [31:0] lsu_address_i,
    input  logic [31:0] lsu_wdata_i,
    input  logic        lsu_kill_i,
    output logic [31:0] lsu_rdata_o,
    output logic        lsu_ready_o,
    output logic        lsu_stall_o,
    output logic        lsu_exception_o,
    output logic [3:0]  lsu_xcause_o,
    output logic [31:0] lsu_mtval_o,
    output logic [31:0] dwbm_addr_o,
    output logic [31:0] dwbm_dat_o,
    output logic [3:0]  dwbm_sel_o,
    output logic        dwbm_cyc_o,
    output logic        dwbm_stb_o,
    output logic        dwbm_we_o,
    input  logic [31:0] dwbm_dat_i,
    input  logic        dwbm_ack_i,
    input  logic        dwbm_err_i
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]  state;
    logic [31:0] addr_q;
    logic [31:0] dat_q;
    logic [31:0] rdata_q;
    logic [3:0]  sel_q;
    logic [1:0]  size_q;
    logic        cyc_q;
    logic        we_q;
    logic        uns_q;
    logic        fault_q;
    logic        discard_q;

    logic        misaligned;
    logic        mis_exc;
    logic        start;
    logic        done_fault;
    logic [3:0]  sel_new;
    logic [31:0] dat_new;
    logic [31:0] load_shifted;
    logic [31:0] load_ext;

    // Alignment check on the presented request; size 11 behaves as a word
    always_comb begin
        misaligned = 1'b0;
        if (lsu_valid_i) begin
            if (lsu_size_i == 2'b01)
                misaligned = lsu_address_i[0];
            else if (lsu_size_i[1])
                misaligned = |lsu_address_i[1:0];
        end
    end

    assign mis_exc    = (state == ST_IDLE) && misaligned;
    assign start      = (state == ST_IDLE) && lsu_valid_i && !misaligned && !lsu_kill_i;
    assign done_fault = (state == ST_DONE) && fault_q && !discard_q;

    // Byte-lane selects and lane-replicated store data for the new request
    always_comb begin
        sel_new = 4'b1111;
        dat_new = lsu_wdata_i;
        case (lsu_size_i)
            2'b00: begin
                sel_new = 4'b0001 << lsu_address_i[1:0];
                dat_new = {4{lsu_wdata_i[7:0]}};
            end
            2'b01: begin
                sel_new = 4'b0011 << {lsu_address_i[1], 1'b0};
                dat_new = {2{lsu_wdata_i[15:0]}};
            end
            default: begin
                sel_new = 4'b1111;
                dat_new = lsu_wdata_i;
            end
        endcase
    end

    // Right-align the addressed lanes of the read data and extend them
    always_comb begin
        load_shifted = dwbm_dat_i >> {addr_q[1:0], 3'b000};
        load_ext     = load_shifted;
        case (size_q)
            2'b00:   load_ext = {{24{load_shifted[7] & ~uns_q}}, load_shifted[7:0]};
            2'b01:   load_ext = {{16{load_shifted[15] & ~uns_q}}, load_shifted[15:0]};
            default: load_ext = load_shifted;
        endcase
    end

    // Transfer sequencer: issue, wait for ack/err, one completion cycle
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= ST_IDLE;
            cyc_q     <= 1'b0;
            we_q      <= 1'b0;
            sel_q     <= 4'b0000;
            addr_q    <= 32'd0;
            dat_q     <= 32'd0;
            rdata_q   <= 32'd0;
            size_q    <= 2'b00;
            uns_q     <= 1'b0;
            fault_q   <= 1'b0;
            discard_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state     <= ST_BUSY;
                        cyc_q     <= 1'b1;
                        we_q      <= lsu_we_i;
                        sel_q     <= sel_new;
                        addr_q    <= lsu_address_i;
                        dat_q     <= dat_new;
                        size_q    <= lsu_size_i;
                        uns_q     <= lsu_unsigned_i;
                        fault_q   <= 1'b0;
                        discard_q <= 1'b0;
                    end
                end
                ST_BUSY: begin
                    // A kill never aborts the bus cycle; it only hides the result
                    if (lsu_kill_i)
                        discard_q <= 1'b1;
                    if (dwbm_ack_i || dwbm_err_i) begin
                        cyc_q <= 1'b0;
                        state <= ST_DONE;
                        if (dwbm_err_i)
                            fault_q <= 1'b1;
                        else if (!we_q)
                            rdata_q <= load_ext;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    cyc_q <= 1'b0;
                end
            endcase
        end
    end

    assign lsu_rdata_o     = rdata_q;
    assign lsu_ready_o     = (state == ST_DONE) && !discard_q && !fault_q;
    assign lsu_stall_o     = lsu_valid_i && !misaligned && (state != ST_DONE);
    assign lsu_exception_o = mis_exc || done_fault;
    assign lsu_xcause_o    = mis_exc    ? (lsu_we_i ? 4'd6 : 4'd4) :
                             done_fault ? (we_q ? 4'd7 : 4'd5) : 4'd0;
    assign lsu_mtval_o     = mis_exc    ? lsu_address_i :
                             done_fault ? addr_q : 32'd0;

    assign dwbm_addr_o = {addr_q[31:2], 2'b00};
    assign dwbm_dat_o  = dat_q;
    assign dwbm_sel_o  = sel_q;
    assign dwbm_cyc_o  = cyc_q;
    assign dwbm_stb_o  = cyc_q;
    assign dwbm_we_o   = we_q;

endmodule

// File: tb/tb_mirfak_lsu.sv
// tb/tb_mirfak_lsu.sv - scoreboard bench for mirfak_lsu with random stimulus
module tb_mirfak_lsu;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        lsu_valid_i;
    logic        lsu_we_i;
    logic [1:0]  lsu_size_i;
    logic        lsu_unsigned_i;
    logic [31:0] lsu_address_i;
    logic [31:0] lsu_wdata_i;
    logic        lsu_kill_i;
    logic [31:0] lsu_rdata_o;
    logic        lsu_ready_o;
    logic        lsu_stall_o;
    logic        lsu_exception_o;
    logic [3:0]  lsu_xcause_o;
    logic [31:0] lsu_mtval_o;
    logic [31:0] dwbm_addr_o;
    logic [31:0] dwbm_dat_o;
    logic [3:0]  dwbm_sel_o;
    logic        dwbm_cyc_o;
    logic        dwbm_stb_o;
    logic        dwbm_we_o;
    logic [31:0] dwbm_dat_i;
    logic        dwbm_ack_i;
    logic        dwbm_err_i;

    always #5 clk = ~clk;

    mirfak_lsu dut (
        .clk_i(clk), .rst_i(rst_i),
        .lsu_valid_i(lsu_valid_i), .lsu_we_i(lsu_we_i), .lsu_size_i(lsu_size_i),
        .lsu_unsigned_i(lsu_unsigned_i), .lsu_address_i(lsu_address_i),
        .lsu_wdata_i(lsu_wdata_i), .lsu_kill_i(lsu_kill_i),
        .lsu_rdata_o(lsu_rdata_o), .lsu_ready_o(lsu_ready_o), .lsu_stall_o(lsu_stall_o),
        .lsu_exception_o(lsu_exception_o), .lsu_xcause_o(lsu_xcause_o),
        .lsu_mtval_o(lsu_mtval_o),
        .dwbm_addr_o(dwbm_addr_o), .dwbm_dat_o(dwbm_dat_o), .dwbm_sel_o(dwbm_sel_o),
        .dwbm_cyc_o(dwbm_cyc_o), .dwbm_stb_o(dwbm_stb_o), .dwbm_we_o(dwbm_we_o),
        .dwbm_dat_i(dwbm_dat_i), .dwbm_ack_i(dwbm_ack_i), .dwbm_err_i(dwbm_err_i)
    );

    typedef struct {
        logic        ready;
        logic        exc;
        logic [3:0]  xcause;
        logic [31:0] mtval;
        logic [31:0] rdata;
        logic        chk_rd;
        int          lat;
    } resp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        we;
    } bus_t;

    resp_t rq[$];
    bus_t  bq[$];
    int    checks = 0;
    int    errors = 0;
    int    vcnt   = 0;
    logic  cyc_prev = 1'b0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: a response is any cycle where a valid request is not stalled
    always @(negedge clk) begin
        resp_t r;
        bus_t  b;
        if (rst_i || !lsu_valid_i) begin
            vcnt = 0;
        end else if (!lsu_stall_o) begin
            if (rq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_response actual=1 required=0");
            end else begin
                r = rq.pop_front();
                check32("ready", 32'(lsu_ready_o), 32'(r.ready));
                check32("exception", 32'(lsu_exception_o), 32'(r.exc));
                check32("latency", vcnt, r.lat);
                check32("cyc_in_resp", 32'(dwbm_cyc_o), 32'd0);
                if (r.exc) begin
                    check32("xcause", 32'(lsu_xcause_o), 32'(r.xcause));
                    check32("mtval", lsu_mtval_o, r.mtval);
                end
                if (r.chk_rd)
                    check32("rdata", lsu_rdata_o, r.rdata);
            end
            vcnt = 0;
        end else begin
            vcnt++;
        end

        if (!rst_i && dwbm_cyc_o && !cyc_prev) begin
            if (bq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_bus_cycle actual=%h required=none", dwbm_addr_o);
            end else begin
                b = bq.pop_front();
                check32("bus_addr", dwbm_addr_o, b.addr);
                check32("bus_sel", 32'(dwbm_sel_o), 32'(b.sel));
                check32("bus_dat", dwbm_dat_o, b.dat);
                check32("bus_we", 32'(dwbm_we_o), 32'(b.we));
                check32("bus_stb", 32'(dwbm_stb_o), 32'd1);
            end
        end
        cyc_prev = dwbm_cyc_o;
    end

    // Driver plus slave: computes expectations from the access rules, then runs the access
    task automatic do_txn(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rdat, input int waits, input logic err,
                          input logic kill, input int kill_at);
        int          nb;
        int          off;
        int          s;
        int          n;
        int          bus_cycles;
        logic        mis;
        logic [31:0] v;
        resp_t       r;
        bus_t        b;
        nb  = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        off = int'(addr % 4);
        mis = (addr % nb) != 0;
        r.ready = 0; r.exc = 0; r.xcause = 0; r.mtval = 0; r.rdata = 0; r.chk_rd = 0;
        r.lat = 0;
        if (mis) begin
            r.exc    = 1;
            r.xcause = we ? 4'd6 : 4'd4;
            r.mtval  = addr;
        end else begin
            s      = ((1 << nb) - 1) << off;
            b.sel  = s[3:0];
            b.addr = addr - (addr % 4);
            b.we   = we;
            if (nb == 1)      b.dat = {24'd0, wdata[7:0]} * 32'h01010101;
            else if (nb == 2) b.dat = {16'd0, wdata[15:0]} * 32'h00010001;
            else              b.dat = wdata;
            bq.push_back(b);
            r.lat = waits + 2;
            if (kill) begin
                r.ready = 0;
            end else if (err) begin
                r.exc    = 1;
                r.xcause = we ? 4'd7 : 4'd5;
                r.mtval  = addr;
            end else begin
                r.ready = 1;
                if (!we) begin
                    v = rdat >> (8 * off);
                    if (nb == 1) begin
                        v = v % 256;
                        if (!uns && v >= 128) v = v + 32'hFFFFFF00;
                    end else if (nb == 2) begin
                        v = v % 65536;
                        if (!uns && v >= 32768) v = v + 32'hFFFF0000;
                    end
                    r.rdata  = v;
                    r.chk_rd = 1;
                end
            end
        end
        rq.push_back(r);

        @(posedge clk); #1;
        lsu_valid_i    = 1;
        lsu_we_i       = we;
        lsu_size_i     = size;
        lsu_unsigned_i = uns;
        lsu_address_i  = addr;
        lsu_wdata_i    = wdata;
        lsu_kill_i     = 0;
        dwbm_ack_i     = 0;
        dwbm_err_i     = 0;
        #1;
        n = 0;
        bus_cycles = 0;
        while (lsu_stall_o) begin
            if (n > 60) begin
                checks++;
                errors++;
                $display("FAIL timeout actual=%0d required=%0d", n, waits + 2);
                break;
            end
            @(posedge clk); #2;
            n++;
            dwbm_ack_i = 0;
            dwbm_err_i = 0;
            dwbm_dat_i = $urandom;
            if (dwbm_cyc_o) begin
                if (kill && bus_cycles == kill_at)
                    lsu_kill_i = 1;
                if (bus_cycles == waits) begin
                    dwbm_err_i = err;
                    dwbm_ack_i = err ? 1'($urandom_range(0, 1)) : 1'b1;
                    dwbm_dat_i = rdat;
                end
                bus_cycles++;
            end
        end
        @(posedge clk); #1;
        lsu_valid_i = 0;
        lsu_kill_i  = 0;
        dwbm_ack_i  = 0;
        dwbm_err_i  = 0;
    endtask

    initial begin
        logic [31:0] a;
        logic [1:0]  sz;
        logic        kl;
        int          w;
        rst_i = 1; lsu_valid_i = 0; lsu_we_i = 0; lsu_size_i = 0; lsu_unsigned_i = 0;
        lsu_address_i = 0; lsu_wdata_i = 0; lsu_kill_i = 0;
        dwbm_dat_i = 0; dwbm_ack_i = 0; dwbm_err_i = 0;
        repeat (2) @(posedge clk);
        #1;
        check32("rst_cyc", 32'(dwbm_cyc_o), 32'd0);
        check32("rst_sel", 32'(dwbm_sel_o), 32'd0);
        check32("rst_addr", dwbm_addr_o, 32'd0);
        check32("rst_rdata", lsu_rdata_o, 32'd0);
        check32("rst_ready", 32'(lsu_ready_o), 32'd0);
        check32("rst_stall", 32'(lsu_stall_o), 32'd0);
        rst_i = 0;

        do_txn(0, 2'd2, 0, 32'h1000, 32'h0, 32'hDEADBEEF, 0, 0, 0, 0);
        do_txn(0, 2'd0, 0, 32'h1003, 32'h0, 32'h80123456, 0, 0, 0, 0);
        do_txn(0, 2'd0, 1, 32'h1003, 32'h0, 32'h80123456, 0, 0, 0, 0);
        do_txn(1, 2'd1, 0, 32'h2002, 32'h1234ABCD, 32'h0, 3, 0, 0, 0);
        do_txn(0, 2'd2, 0, 32'h1001, 32'h0, 32'h0, 0, 0, 0, 0);
        do_txn(1, 2'd1, 0, 32'h2001, 32'h55AA, 32'h0, 0, 0, 0, 0);
        do_txn(1, 2'd2, 0, 32'h2004, 32'hCAFEF00D, 32'h0, 1, 1, 0, 0);
        do_txn(0, 2'd2, 0, 32'h1008, 32'h0, 32'h11223344, 4, 0, 1, 2);
        do_txn(0, 2'd1, 0, 32'h100E, 32'h0, 32'h8001FFFF, 0, 0, 0, 0);

        // Reset in the middle of a bus cycle, then a stray ack afterwards
        begin
            bus_t b;
            b.addr = 32'h3000; b.sel = 4'hF; b.dat = 32'h0BADF00D; b.we = 0;
            bq.push_back(b);
            @(posedge clk); #1;
            lsu_valid_i = 1; lsu_we_i = 0; lsu_size_i = 2'd2; lsu_unsigned_i = 0;
            lsu_address_i = 32'h3000; lsu_wdata_i = 32'h0BADF00D;
            repeat (3) @(posedge clk);
            #1;
            rst_i = 1; lsu_valid_i = 0;
            @(posedge clk); #1;
            check32("midrst_cyc", 32'(dwbm_cyc_o), 32'd0);
            check32("midrst_stb", 32'(dwbm_stb_o), 32'd0);
            check32("midrst_we", 32'(dwbm_we_o), 32'd0);
            check32("midrst_sel", 32'(dwbm_sel_o), 32'd0);
            check32("midrst_addr", dwbm_addr_o, 32'd0);
            check32("midrst_dat", dwbm_dat_o, 32'd0);
            rst_i = 0; dwbm_ack_i = 1; dwbm_dat_i = 32'hFFFFFFFF;
            @(posedge clk); #1;
            dwbm_ack_i = 0;
            check32("stray_ack_ready", 32'(lsu_ready_o), 32'd0);
            check32("stray_ack_cyc", 32'(dwbm_cyc_o), 32'd0);
            check32("stray_ack_rdata", lsu_rdata_o, 32'd0);
        end

        for (int i = 0; i < 80; i++) begin
            a  = $urandom;
            sz = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'd1) a[0] = 1'b0;
                else if (sz != 2'd0) a[1:0] = 2'b00;
            end
            w  = $urandom_range(0, 4);
            kl = ($urandom_range(0, 7) == 0);
            do_txn(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom,
                   $urandom, w, ($urandom_range(0, 5) == 0), kl, $urandom_range(0, w));
        end

        repeat (3) @(posedge clk);
        #1;
        check32("resp_queue_empty", rq.size(), 32'd0);
        check32("bus_queue_empty", bq.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
